// File: rtl/life_array.sv
// Parametrised Conway Game-of-Life cell array with single-cell writes,
// per-clock generation stepping and a raster-order serial scan-out port.
module life_array #(
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    parameter  int WRAP  = 0,
    parameter  int GEN_W = 16,
    localparam int RW    = (ROWS > 2) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 2) ? $clog2(COLS) : 1,
    localparam int N     = ROWS * COLS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RW-1:0]    row,
    input  logic [CW-1:0]    col,
    input  logic             val,
    input  logic             write_enb,
    input  logic             scan,
    input  logic             run,
    output logic [N-1:0]     alive,
    output logic [GEN_W-1:0] generation,
    output logic             scan_valid,
    output logic [RW-1:0]    scan_row,
    output logic [CW-1:0]    scan_col,
    output logic             scan_val,
    output logic             scan_last
);

    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [N-1:0]  next_s;
    logic [N-1:0]  wsel_s;
    logic          beat_s;
    logic          restart_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] beat_idx_s;
    logic [RW-1:0] pos_row_r;
    logic [RW-1:0] beat_row_s;
    logic [RW-1:0] nrow_s;
    logic [CW-1:0] pos_col_r;
    logic [CW-1:0] beat_col_s;
    logic [CW-1:0] ncol_s;

    // Neighbour indices are elaboration-time constants; off-board
    // neighbours are forced to 0 unless the board is toroidal.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int UP  = (gr == 0) ? ROWS - 1 : gr - 1;
            localparam int DN  = (gr == ROWS - 1) ? 0 : gr + 1;
            localparam int LF  = (gc == 0) ? COLS - 1 : gc - 1;
            localparam int RT  = (gc == COLS - 1) ? 0 : gc + 1;
            localparam bit UOK = (WRAP != 0) || (gr > 0);
            localparam bit DOK = (WRAP != 0) || (gr < ROWS - 1);
            localparam bit LOK = (WRAP != 0) || (gc > 0);
            localparam bit ROK = (WRAP != 0) || (gc < COLS - 1);

            logic [7:0] nb_s;
            logic [3:0] cnt_s;

            assign nb_s[0] = (UOK && LOK) ? alive[UP*COLS + LF] : 1'b0;
            assign nb_s[1] = UOK          ? alive[UP*COLS + gc] : 1'b0;
            assign nb_s[2] = (UOK && ROK) ? alive[UP*COLS + RT] : 1'b0;
            assign nb_s[3] = LOK          ? alive[gr*COLS + LF] : 1'b0;
            assign nb_s[4] = ROK          ? alive[gr*COLS + RT] : 1'b0;
            assign nb_s[5] = (DOK && LOK) ? alive[DN*COLS + LF] : 1'b0;
            assign nb_s[6] = DOK          ? alive[DN*COLS + gc] : 1'b0;
            assign nb_s[7] = (DOK && ROK) ? alive[DN*COLS + RT] : 1'b0;

            // Population count of the eight neighbours.
            always_comb begin
                cnt_s = 4'd0;
                for (int k = 0; k < 8; k++) begin
                    cnt_s = cnt_s + {3'd0, nb_s[k]};
                end
            end

            assign next_s[gr*COLS + gc] = (cnt_s == 4'd3) ||
                                          (alive[gr*COLS + gc] && (cnt_s == 4'd2));
            // Out-of-range addresses never match any cell, so they are dropped.
            assign wsel_s[gr*COLS + gc] = (row == RW'(gr)) && (col == CW'(gc));
        end
    end

    // Scan FSM next-state; scan_last marks that the final beat is already out.
    always_comb begin
        state_s   = state_r;
        beat_s    = 1'b0;
        restart_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (scan) begin
                    state_s   = SCAN;
                    beat_s    = 1'b1;
                    restart_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (!scan || scan_last) begin
                    state_s = IDLE;
                end else begin
                    beat_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Position of the beat emitted at this edge and its raster successor.
    always_comb begin
        if (restart_s) begin
            beat_idx_s = '0;
            beat_row_s = '0;
            beat_col_s = '0;
        end else begin
            beat_idx_s = idx_r;
            beat_row_s = pos_row_r;
            beat_col_s = pos_col_r;
        end
        if (beat_col_s == CW'(COLS - 1)) begin
            ncol_s = '0;
            nrow_s = beat_row_s + RW'(1);
        end else begin
            ncol_s = beat_col_s + CW'(1);
            nrow_s = beat_row_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Board and generation: write beats step, stepping frozen while scanning.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive      <= '0;
            generation <= '0;
        end else if (write_enb) begin
            alive <= (alive & ~wsel_s) | (wsel_s & {N{val}});
        end else if (run && (state_r == IDLE)) begin
            alive      <= next_s;
            generation <= generation + GEN_W'(1);
        end
    end

    // Scan-out beat registers; row/col hold when no beat is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_valid <= 1'b0;
            scan_row   <= '0;
            scan_col   <= '0;
            scan_val   <= 1'b0;
            scan_last  <= 1'b0;
            idx_r      <= '0;
            pos_row_r  <= '0;
            pos_col_r  <= '0;
        end else if (beat_s) begin
            scan_valid <= 1'b1;
            scan_row   <= beat_row_s;
            scan_col   <= beat_col_s;
            scan_val   <= alive[beat_idx_s];
            scan_last  <= (beat_idx_s == IW'(N - 1));
            idx_r      <= beat_idx_s + IW'(1);
            pos_row_r  <= nrow_s;
            pos_col_r  <= ncol_s;
        end else begin
            scan_valid <= 1'b0;
            scan_val   <= 1'b0;
            scan_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_array.sv
// Bench for life_array: three configurations share one stimulus stream and are
// compared every cycle against a behavioural model, plus hand-checked tables.
module tb_life_array;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  row, col;
    logic        val, write_enb, scan, run;

    logic [15:0] alive0, alive1;
    logic [8:0]  alive2;
    logic [15:0] gen0, gen1, gen2;
    logic        sv0, sv1, sv2, sl0, sl1, sl2, sx0, sx1, sx2;
    logic [1:0]  sr0, sr1, sr2, sc0, sc1, sc2;

    int vectors;
    int errors;

    always #5 clk = ~clk;

    life_array #(.ROWS(4), .COLS(4), .WRAP(0), .GEN_W(16)) dut0 (
        .clk(clk), .reset(reset), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .scan(scan), .run(run), .alive(alive0),
        .generation(gen0), .scan_valid(sv0), .scan_row(sr0), .scan_col(sc0),
        .scan_val(sx0), .scan_last(sl0));

    life_array #(.ROWS(4), .COLS(4), .WRAP(1), .GEN_W(16)) dut1 (
        .clk(clk), .reset(reset), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .scan(scan), .run(run), .alive(alive1),
        .generation(gen1), .scan_valid(sv1), .scan_row(sr1), .scan_col(sc1),
        .scan_val(sx1), .scan_last(sl1));

    life_array #(.ROWS(3), .COLS(3), .WRAP(1), .GEN_W(16)) dut2 (
        .clk(clk), .reset(reset), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .scan(scan), .run(run), .alive(alive2),
        .generation(gen2), .scan_valid(sv2), .scan_row(sr2), .scan_col(sc2),
        .scan_val(sx2), .scan_last(sl2));

    logic [15:0] o_alive [3];
    logic [15:0] o_gen   [3];
    logic        o_sv    [3];
    logic        o_sl    [3];
    logic        o_sx    [3];
    logic [1:0]  o_sr    [3];
    logic [1:0]  o_sc    [3];

    assign o_alive[0] = alive0;
    assign o_alive[1] = alive1;
    assign o_alive[2] = {7'd0, alive2};
    assign o_gen[0] = gen0;
    assign o_gen[1] = gen1;
    assign o_gen[2] = gen2;
    assign o_sv[0] = sv0;
    assign o_sv[1] = sv1;
    assign o_sv[2] = sv2;
    assign o_sl[0] = sl0;
    assign o_sl[1] = sl1;
    assign o_sl[2] = sl2;
    assign o_sx[0] = sx0;
    assign o_sx[1] = sx1;
    assign o_sx[2] = sx2;
    assign o_sr[0] = sr0;
    assign o_sr[1] = sr1;
    assign o_sr[2] = sr2;
    assign o_sc[0] = sc0;
    assign o_sc[1] = sc1;
    assign o_sc[2] = sc2;

    // Reference model state, one slot per configuration.
    int          mr [3] = '{4, 4, 3};
    int          mc [3] = '{4, 4, 3};
    bit          mw [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] mb [3];
    logic [15:0] mg [3];
    bit          mv [3];
    bit          mx [3];
    int          mk [3];

    function automatic logic [15:0] life_next(logic [15:0] b, int nr, int nc, bit w);
        logic [15:0] o;
        o = '0;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0)) begin
                            if (w) begin
                                rr = (rr + nr) % nr;
                                cc = (cc + nc) % nc;
                                n += int'(b[rr*nc + cc]);
                            end else if (rr >= 0 && rr < nr && cc >= 0 && cc < nc) begin
                                n += int'(b[rr*nc + cc]);
                            end
                        end
                    end
                end
                o[r*nc + c] = b[r*nc + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mb[d] = '0;
            mg[d] = '0;
            mv[d] = 1'b0;
            mx[d] = 1'b0;
            mk[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            logic [15:0] pre;
            pre = mb[d];
            if (write_enb) begin
                if (int'(row) < mr[d] && int'(col) < mc[d])
                    mb[d][int'(row)*mc[d] + int'(col)] = val;
            end else if (run && !mv[d]) begin
                mb[d] = life_next(mb[d], mr[d], mc[d], mw[d]);
                mg[d] = mg[d] + 16'd1;
            end
            if (!mv[d]) begin
                if (scan) begin
                    mv[d] = 1'b1;
                    mk[d] = 0;
                    mx[d] = pre[0];
                end
            end else if (!scan || mk[d] == mr[d]*mc[d] - 1) begin
                mv[d] = 1'b0;
            end else begin
                mk[d] = mk[d] + 1;
                mx[d] = pre[mk[d]];
            end
        end
    endtask

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            chk("alive", d, 32'(o_alive[d]), 32'(mb[d]));
            chk("generation", d, 32'(o_gen[d]), 32'(mg[d]));
            chk("scan_valid", d, 32'(o_sv[d]), 32'(mv[d]));
            chk("scan_last", d, 32'(o_sl[d]), 32'(mv[d] && mk[d] == mr[d]*mc[d] - 1));
            chk("scan_row", d, 32'(o_sr[d]), 32'(mk[d] / mc[d]));
            chk("scan_col", d, 32'(o_sc[d]), 32'(mk[d] % mc[d]));
            if (mv[d]) chk("scan_val", d, 32'(o_sx[d]), 32'(mx[d]));
        end
    endtask

    task automatic drive(bit we, int r, int c, bit v, bit rn, bit sc);
        write_enb = we;
        row       = 2'(r);
        col       = 2'(c);
        val       = v;
        run       = rn;
        scan      = sc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        reset = 1'b1;
    endtask

    typedef struct {
        bit          we;
        int          r;
        int          c;
        bit          v;
        bit          rn;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] g;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{1'b1, 0, 0, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'd0};
        tbl[1]  = '{1'b1, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd0};
        tbl[2]  = '{1'b1, 1, 0, 1'b1, 1'b0, 16'h0010, 16'h0010, 16'd0};
        tbl[3]  = '{1'b1, 1, 1, 1'b1, 1'b0, 16'h0030, 16'h0030, 16'd0};
        tbl[4]  = '{1'b1, 1, 2, 1'b1, 1'b1, 16'h0070, 16'h0070, 16'd0};
        tbl[5]  = '{1'b0, 0, 0, 1'b0, 1'b1, 16'h0222, 16'h0222, 16'd1};
        tbl[6]  = '{1'b0, 0, 0, 1'b0, 1'b1, 16'h0070, 16'h0070, 16'd2};
        tbl[7]  = '{1'b0, 0, 0, 1'b0, 1'b1, 16'h0222, 16'h0222, 16'd3};
        tbl[8]  = '{1'b1, 0, 1, 1'b0, 1'b0, 16'h0220, 16'h0220, 16'd3};
        tbl[9]  = '{1'b1, 1, 1, 1'b0, 1'b0, 16'h0200, 16'h0200, 16'd3};
        tbl[10] = '{1'b1, 2, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd3};
        tbl[11] = '{1'b1, 0, 0, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'd3};
        tbl[12] = '{1'b1, 0, 3, 1'b1, 1'b0, 16'h0009, 16'h0009, 16'd3};
        tbl[13] = '{1'b1, 3, 0, 1'b1, 1'b0, 16'h1009, 16'h1009, 16'd3};
        tbl[14] = '{1'b1, 3, 3, 1'b1, 1'b0, 16'h9009, 16'h9009, 16'd3};
        tbl[15] = '{1'b0, 0, 0, 1'b0, 1'b1, 16'h0000, 16'h9009, 16'd4};
        tbl[16] = '{1'b1, 1, 1, 1'b1, 1'b1, 16'h0020, 16'h9029, 16'd4};
        tbl[17] = '{1'b0, 0, 0, 1'b0, 1'b0, 16'h0020, 16'h9029, 16'd4};

        vectors = 0;
        errors  = 0;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Hand-derived write / blinker / corner / priority vectors.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].we, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].rn, 1'b0);
            tick();
            chk("tbl_alive_nowrap", 0, 32'(alive0), 32'(tbl[i].a0));
            chk("tbl_alive_wrap", 1, 32'(alive1), 32'(tbl[i].a1));
            chk("tbl_generation", 0, 32'(gen0), 32'(tbl[i].g));
        end

        // Out-of-range write on the 3x3 board.
        pulse_reset();
        drive(1'b1, 3, 3, 1'b1, 1'b0, 1'b0);
        tick();
        chk("oor_alive3x3", 2, 32'(alive2), 32'h000);
        chk("oor_alive4x4", 0, 32'(alive0), 32'h8000);
        drive(1'b1, 2, 2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("inrange_alive3x3", 2, 32'(alive2), 32'h100);

        // Full scan with run held mid-scan, idle gap, restart and abort.
        pulse_reset();
        drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            run = (k >= 2 && k <= 10);
            tick();
            chk("beat_valid", 0, 32'(sv0), 32'd1);
            chk("beat_row", 0, 32'(sr0), 32'(k / 4));
            chk("beat_col", 0, 32'(sc0), 32'(k % 4));
            chk("beat_val", 0, 32'(sx0), 32'(k == 0));
            chk("beat_last", 0, 32'(sl0), 32'(k == 15));
        end
        run = 1'b0;
        chk("scan_frozen_gen", 0, 32'(gen0), 32'd0);
        chk("scan_frozen_alive", 0, 32'(alive0), 32'h0001);
        tick();
        chk("gap_valid", 0, 32'(sv0), 32'd0);
        chk("gap_last", 0, 32'(sl0), 32'd0);
        tick();
        chk("restart_valid", 0, 32'(sv0), 32'd1);
        chk("restart_row", 0, 32'(sr0), 32'd0);
        for (int k = 1; k <= 7; k++) tick();
        chk("beat7_col", 0, 32'(sc0), 32'd3);
        scan = 1'b0;
        tick();
        chk("abort_valid", 0, 32'(sv0), 32'd0);
        chk("abort_hold_row", 0, 32'(sr0), 32'd1);

        // Asynchronous reset in the middle of a scan.
        scan = 1'b1;
        repeat (3) tick();
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 0, 32'(sv0), 32'd0);
        chk("async_rst_alive", 0, 32'(alive0), 32'd0);
        model_reset();
        compare_all();
        reset = 1'b1;
        scan = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            write_enb = ($urandom_range(0, 3) == 0);
            row       = 2'($urandom_range(0, 3));
            col       = 2'($urandom_range(0, 3));
            val       = ($urandom_range(0, 2) != 0);
            run       = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) scan = ~scan;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
